morse_symbolizer: RTL and testbench

//  Consumes the debounced key level (debounce.db_btn_o) and classifies activity into Morse symbols:

---
 rtl/morse_decoder_pkg.sv | 24 ++
 rtl/morse_symbolizer_tick_gen.sv | 33 +++
 rtl/morse_symbolizer.sv | 112 +++++++++++
 tb/tb_morse_symbolizer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_decoder_pkg.sv
// Shared Morse symbol/state types and default timing constants for the key symbolizer.
// Latency: n/a (types only); backpressure: n/a.
package morse_decoder_pkg;

  typedef enum logic [1:0] {
    SYM_DOT,
    SYM_DASH,
    SYM_LETTER_END,
    SYM_WORD_END
  } morse_sym_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_LETTER_DONE
  } morse_state_t;

  localparam int TICK_CYCLES_C      = 100000;
  localparam int DASH_MIN_TICKS_C   = 200;
  localparam int LETTER_GAP_TICKS_C = 600;
  localparam int WORD_GAP_TICKS_C   = 1400;

endpackage

// File: rtl/morse_symbolizer_tick_gen.sv
// Prescaler: counts 0..TICK_CYCLES-1 and pulses tick_o in the last count; clear_i restarts at 0.
// Latency: tick_o is combinational from the count; backpressure: none.
module tick_gen
  import morse_decoder_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_C
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST_C);
  assign tick_o = w_wrap;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clear_i || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_symbolizer.sv
// Classifies key press/idle durations into DOT/DASH/LETTER_END/WORD_END symbols.
// Latency: symbol valid the edge after its trigger; backpressure: held until accepted, new symbols dropped (sticky overflow) while stalled.
module morse_symbolizer
  import morse_decoder_pkg::*;
#(
  parameter int TICK_CYCLES      = TICK_CYCLES_C,
  parameter int DASH_MIN_TICKS   = DASH_MIN_TICKS_C,
  parameter int LETTER_GAP_TICKS = LETTER_GAP_TICKS_C,
  parameter int WORD_GAP_TICKS   = WORD_GAP_TICKS_C
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       db_btn_i,
  output morse_sym_t sym_o,
  output logic       sym_valid_o,
  input  logic       sym_ready_i,
  output logic       overflow_o
);

  localparam int DW = $clog2(WORD_GAP_TICKS + 1);

  morse_state_t r_state, w_state_nxt;
  morse_sym_t   r_sym, w_emit_sym;
  logic         r_btn_q, r_valid, r_overflow;
  logic [DW-1:0] r_dur, w_dur_eff;
  logic         w_rise, w_fall, w_edge, w_tick, w_emit;

  assign w_rise = db_btn_i & ~r_btn_q;
  assign w_fall = ~db_btn_i & r_btn_q;
  assign w_edge = w_rise | w_fall;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .clear_i(w_edge),
    .tick_o (w_tick)
  );

  // A tick landing in the same cycle as a decision counts toward that decision.
  assign w_dur_eff = (w_tick && (r_dur != '1)) ? r_dur + 1'b1 : r_dur;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_q <= 1'b0;
      r_dur   <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_btn_q <= db_btn_i;
      r_dur   <= w_edge ? '0 : w_dur_eff;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_sym  = SYM_DOT;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_PRESS;
      end
      ST_PRESS: begin
        if (w_fall) begin
          w_emit      = 1'b1;
          w_emit_sym  = (w_dur_eff >= DW'(DASH_MIN_TICKS)) ? SYM_DASH : SYM_DOT;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESS;
        end else if (w_tick && (w_dur_eff == DW'(LETTER_GAP_TICKS))) begin
          w_emit      = 1'b1;
          w_emit_sym  = SYM_LETTER_END;
          w_state_nxt = ST_LETTER_DONE;
        end
      end
      ST_LETTER_DONE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESS;
        end else if (w_tick && (w_dur_eff == DW'(WORD_GAP_TICKS))) begin
          w_emit      = 1'b1;
          w_emit_sym  = SYM_WORD_END;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sym      <= SYM_DOT;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_emit && (!r_valid || sym_ready_i)) begin
      r_sym   <= w_emit_sym;
      r_valid <= 1'b1;
    end else if (w_emit) begin
      r_overflow <= 1'b1;
    end else if (r_valid && sym_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign sym_o       = r_sym;
  assign sym_valid_o = r_valid;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_morse_symbolizer.sv
// Scoreboard bench for morse_symbolizer: key patterns are expanded into expected symbols by duration rules.
module tb_morse_symbolizer;
  import morse_decoder_pkg::*;

  localparam int TICK   = 4;
  localparam int DASH_T = 3;
  localparam int LET_T  = 6;
  localparam int WORD_T = 14;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       db_btn_i = 1'b0;
  logic       sym_ready_i = 1'b1;
  morse_sym_t sym_o;
  logic       sym_valid_o;
  logic       overflow_o;

  typedef struct {
    morse_sym_t sym;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  morse_symbolizer #(
    .TICK_CYCLES     (TICK),
    .DASH_MIN_TICKS  (DASH_T),
    .LETTER_GAP_TICKS(LET_T),
    .WORD_GAP_TICKS  (WORD_T)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .db_btn_i   (db_btn_i),
    .sym_o      (sym_o),
    .sym_valid_o(sym_valid_o),
    .sym_ready_i(sym_ready_i),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input morse_sym_t s, input int c);
    exp_t e;
    e.sym = s;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Reference rules: a press spanning len cycles covers len/TICK ticks; a gap of
  // g cycles closes a letter only if it outlasts LET_T ticks (a rise on the
  // threshold tick wins), likewise for a word. Gap symbols count from the release.
  task automatic expect_release(input int hi, input int lo, input int d, input bit timed);
    push(((hi / TICK) >= DASH_T) ? SYM_DASH : SYM_DOT, timed ? d + 1 : -1);
    if (lo > LET_T * TICK)  push(SYM_LETTER_END, d + 1 + LET_T * TICK);
    if (lo > WORD_T * TICK) push(SYM_WORD_END, d + 1 + WORD_T * TICK);
  endtask

  task automatic press_gap(input int hi, input int lo);
    int d;
    db_btn_i = 1'b1;
    step(hi);
    db_btn_i = 1'b0;
    d = cyc;
    expect_release(hi, lo, d, 1'b1);
    step(lo);
  endtask

  task automatic monitor_loop();
    bit         prev_stall = 1'b0;
    morse_sym_t prev_sym = SYM_DOT;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (prev_stall && sym_valid_o) chk("hold_stable", int'(sym_o), int'(prev_sym));
        if (sym_valid_o && sym_ready_i) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_symbol: got %0d expected none (cycle %0d)", int'(sym_o), cyc);
          end else begin
            e = sb_q.pop_front();
            chk("symbol", int'(sym_o), int'(e.sym));
            if (e.cyc >= 0) chk("symbol_cycle", cyc, e.cyc);
          end
        end
      end
      prev_stall = resetn && sym_valid_o && !sym_ready_i;
      prev_sym   = sym_o;
    end
  endtask

  initial begin
    int d;
    fork
      monitor_loop();
    join_none

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(sym_valid_o), 0);
    chk("rst_sym", int'(sym_o), int'(SYM_DOT));
    chk("rst_overflow", int'(overflow_o), 0);
    step(1);
    resetn = 1'b1;
    step(3);

    // Basic DOT / LETTER_END / WORD_END timing.
    press_gap(8, 60);
    // DASH threshold and saturation on a very long press.
    press_gap(12, 30);
    press_gap(11, 30);
    press_gap(200, 60);
    // Letter continuation and gap boundaries.
    press_gap(8, 20);
    press_gap(8, 40);
    press_gap(8, 24);
    press_gap(8, 25);
    press_gap(8, 56);
    press_gap(8, 57);

    // Randomized key activity.
    for (int i = 0; i < 40; i++) begin
      press_gap(int'($urandom_range(70, 1)), int'($urandom_range(70, 1)));
    end
    press_gap(5, 60);

    // Acceptance in the same cycle as a new emit.
    sym_ready_i = 1'b0;
    db_btn_i = 1'b1;
    step(8);
    db_btn_i = 1'b0;
    push(SYM_DOT, -1);
    step(4);
    db_btn_i = 1'b1;
    step(12);
    db_btn_i = 1'b0;
    sym_ready_i = 1'b1;
    d = cyc;
    expect_release(12, 60, d, 1'b1);
    step(1);
    @(negedge clk);
    chk("same_cycle_valid", int'(sym_valid_o), 1);
    chk("same_cycle_sym", int'(sym_o), int'(SYM_DASH));
    chk("same_cycle_overflow", int'(overflow_o), 0);
    step(60);

    // Overflow while stalled.
    sym_ready_i = 1'b0;
    db_btn_i = 1'b1;
    step(8);
    db_btn_i = 1'b0;
    push(SYM_DOT, -1);
    step(4);
    db_btn_i = 1'b1;
    step(12);
    db_btn_i = 1'b0;
    d = cyc;
    push(SYM_LETTER_END, d + 1 + LET_T * TICK);
    push(SYM_WORD_END, d + 1 + WORD_T * TICK);
    step(2);
    @(negedge clk);
    chk("ovf_held_sym", int'(sym_o), int'(SYM_DOT));
    chk("ovf_held_valid", int'(sym_valid_o), 1);
    chk("ovf_flag", int'(overflow_o), 1);
    step(1);
    sym_ready_i = 1'b1;
    step(1);
    @(negedge clk);
    chk("ovf_after_accept_valid", int'(sym_valid_o), 0);
    chk("ovf_sticky", int'(overflow_o), 1);
    step(60);

    // Asynchronous reset mid-press, then a key already high at reset release.
    db_btn_i = 1'b1;
    step(10);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", int'(sym_valid_o), 0);
    chk("async_rst_overflow", int'(overflow_o), 0);
    chk("async_rst_sym", int'(sym_o), int'(SYM_DOT));
    step(2);
    resetn = 1'b1;
    step(8);
    db_btn_i = 1'b0;
    d = cyc;
    expect_release(8, 60, d, 1'b1);
    step(60);

    chk("queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
